// File: rtl/mesh_link_buffer_if.sv
// Mesh link handshake bundle: upstream send/ready/data plus downstream send/ready/data.
// The buffer sits on the slave modport; the surrounding router or bench uses master.
interface mesh_link_buffer_if #(
  parameter int PACKET_WIDTH = 64
);
  // Handshake: a packet moves upstream when si && ri in the same cycle. It moves
  // downstream when so is high, and so is only raised while ro is high.
  // ri/so/dout depend only on registered state, polarity and ro, never on si/di.
  logic                    si;
  logic                    ri;
  logic [PACKET_WIDTH-1:0] di;
  logic                    so;
  logic                    ro;
  logic [PACKET_WIDTH-1:0] dout;

  modport master (
    output si,
    output di,
    output ro,
    input  ri,
    input  so,
    input  dout
  );

  modport slave (
    input  si,
    input  di,
    input  ro,
    output ri,
    output so,
    output dout
  );
endinterface

// File: rtl/mesh_link_buffer.sv
// Two-VC elastic link buffer with a free-running polarity. In each cycle one VC is
// written and the other is read, so neither FIFO ever sees a push and a pop together.
module mesh_link_buffer #(
  parameter int PACKET_WIDTH = 64,
  parameter int DEPTH        = 2,
  parameter int VC_BIT       = 63,
  localparam int OCC_W       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  mesh_link_buffer_if.slave link,
  output logic             polarity_out,
  output logic [OCC_W-1:0] occ_even,
  output logic [OCC_W-1:0] occ_odd,
  output logic             err_vc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  logic                    polarity;
  logic                    err_q;
  logic [PACKET_WIDTH-1:0] mem    [2][DEPTH];
  logic [PTR_W-1:0]        wr_ptr [2];
  logic [PTR_W-1:0]        rd_ptr [2];
  logic [OCC_W-1:0]        occ    [2];

  logic wr_vc;
  logic rd_vc;
  logic ri_int;
  logic so_int;
  logic push;
  logic wrong_vc;

  // VC index 0 is even, 1 is odd; polarity names the VC that is written this cycle.
  always_comb begin
    wr_vc    = polarity;
    rd_vc    = ~polarity;
    ri_int   = occ[wr_vc] < OCC_FULL;
    so_int   = link.ro && (occ[rd_vc] != '0);
    push     = link.si && ri_int && (link.di[VC_BIT] == polarity);
    wrong_vc = link.si && (link.di[VC_BIT] != polarity);
  end

  assign link.ri      = ri_int;
  assign link.so      = so_int;
  assign link.dout    = so_int ? mem[rd_vc][rd_ptr[rd_vc]] : '0;
  assign polarity_out = polarity;
  assign occ_even     = occ[0];
  assign occ_odd      = occ[1];
  assign err_vc       = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      polarity <= 1'b0;
      err_q    <= 1'b0;
      for (int v = 0; v < 2; v++) begin
        wr_ptr[v] <= '0;
        rd_ptr[v] <= '0;
        occ[v]    <= '0;
      end
    end else begin
      polarity <= ~polarity;
      if (wrong_vc) begin
        err_q <= 1'b1;
      end
      // wr_vc and rd_vc always differ, so these two updates never collide.
      if (push) begin
        wr_ptr[wr_vc] <= wr_ptr[wr_vc] + PTR_W'(1);
        occ[wr_vc]    <= occ[wr_vc] + OCC_W'(1);
      end
      if (so_int) begin
        rd_ptr[rd_vc] <= rd_ptr[rd_vc] + PTR_W'(1);
        occ[rd_vc]    <= occ[rd_vc] - OCC_W'(1);
      end
    end
  end

  // Storage needs no reset: occupancy gates every read and is cleared by reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_vc][wr_ptr[wr_vc]] <= link.di;
    end
  end

endmodule

// File: tb/tb_mesh_link_buffer.sv
// Bench for mesh_link_buffer: a per-VC scoreboard driven by an independent polarity
// and occupancy model, checked at every falling edge.
module tb_mesh_link_buffer;
  localparam int W      = 64;
  localparam int DEPTH  = 2;
  localparam int VC_BIT = 63;
  localparam int OCC_W  = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             polarity_out;
  logic [OCC_W-1:0] occ_even;
  logic [OCC_W-1:0] occ_odd;
  logic             err_vc;

  mesh_link_buffer_if #(.PACKET_WIDTH(W)) link ();

  mesh_link_buffer #(
    .PACKET_WIDTH(W),
    .DEPTH       (DEPTH),
    .VC_BIT      (VC_BIT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .link        (link),
    .polarity_out(polarity_out),
    .occ_even    (occ_even),
    .occ_odd     (occ_odd),
    .err_vc      (err_vc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_even[$];
  logic [W-1:0] exp_odd[$];
  logic exp_pol = 1'b0;
  logic exp_err = 1'b0;
  logic rand_done = 1'b0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic int occ_of(input logic vc);
    return vc ? exp_odd.size() : exp_even.size();
  endfunction

  // Mid-cycle: compare outputs with the model, then advance the model to the next cycle.
  always @(negedge clk) begin
    logic         e_ri;
    logic         e_so;
    logic [W-1:0] e_do;
    if (reset === 1'b1) begin
      e_ri = occ_of(exp_pol) < DEPTH;
      e_so = (link.ro === 1'b1) && (occ_of(~exp_pol) > 0);
      e_do = '0;
      if (e_so) e_do = exp_pol ? exp_even[0] : exp_odd[0];
      check("polarity", polarity_out, exp_pol);
      check("ri", link.ri, e_ri);
      check("so", link.so, e_so);
      check("dout", link.dout, e_do);
      check("occ_even", occ_even, exp_even.size());
      check("occ_odd", occ_odd, exp_odd.size());
      check("err_vc", err_vc, exp_err);
      if (e_so) begin
        if (exp_pol) void'(exp_even.pop_front());
        else         void'(exp_odd.pop_front());
      end
      if (link.si && e_ri && link.di[VC_BIT] == exp_pol) begin
        if (exp_pol) exp_odd.push_back(link.di);
        else         exp_even.push_back(link.di);
      end
      if (link.si && link.di[VC_BIT] != exp_pol) exp_err = 1'b1;
      exp_pol = ~exp_pol;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; reset is released before the falling edge.
  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    check("rst_polarity", polarity_out, 1'b0);
    check("rst_occ_even", occ_even, 0);
    check("rst_occ_odd", occ_odd, 0);
    check("rst_err_vc", err_vc, 1'b0);
    check("rst_so", link.so, 1'b0);
    check("rst_dout", link.dout, 0);
    check("rst_ri", link.ri, 1'b1);
    exp_even.delete();
    exp_odd.delete();
    exp_pol = 1'b0;
    exp_err = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  // Offers a packet only in cycles of its own VC phase, holding it until accepted.
  task automatic send(input logic [W-1:0] d);
    logic acc;
    int   tries;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 40) begin
      while (exp_pol != d[VC_BIT]) cycle();
      link.si = 1'b1;
      link.di = d;
      @(negedge clk);
      acc = link.ri;
      tries++;
      cycle();
      link.si = 1'b0;
    end
    check("send_accept", acc, 1'b1);
  endtask

  initial begin
    logic [W-1:0] pkt;
    link.si = 1'b0;
    link.di = '0;
    link.ro = 1'b1;
    reset   = 1'b0;
    cycle();
    pulse_reset();

    // Idle after reset.
    repeat (10) cycle();

    // Single even packet with minimum latency.
    send(64'h0000_0000_0000_00A5);
    repeat (3) cycle();

    // Fill the even VC with the sink stalled, then release it while 0x3 waits.
    link.ro = 1'b0;
    send(64'h1);
    send(64'h2);
    fork
      send(64'h3);
      begin
        repeat (6) cycle();
        link.ro = 1'b1;
      end
    join
    repeat (4) cycle();

    // Even-tagged packet offered in an odd cycle.
    while (exp_pol != 1'b1) cycle();
    link.si = 1'b1;
    link.di = 64'h7;
    cycle();
    link.si = 1'b0;
    repeat (4) cycle();
    check("err_sticky", err_vc, 1'b1);

    // Back-to-back even then odd traffic.
    link.ro = 1'b1;
    send(64'h10);
    send(64'h8000_0000_0000_0020);
    repeat (4) cycle();
    check("conc_occ_even", occ_even, 0);
    check("conc_occ_odd", occ_odd, 0);

    // Random packets against random downstream stalls.
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          pkt = {$urandom, $urandom};
          send(pkt);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          link.ro = ($urandom_range(0, 3) != 0);
          cycle();
        end
      end
    join
    link.ro = 1'b1;
    repeat (8) cycle();
    check("drain_occ_even", occ_even, 0);
    check("drain_occ_odd", occ_odd, 0);

    // Reset with both VCs holding packets.
    link.ro = 1'b0;
    send(64'h11);
    send(64'h12);
    send(64'h8000_0000_0000_0013);
    cycle();
    check("pre_rst_occ_even", occ_even, 2);
    check("pre_rst_occ_odd", occ_odd, 1);
    link.ro = 1'b1;
    pulse_reset();
    repeat (6) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mesh_link_buffer.md
# mesh_link_buffer

Parametrised two-virtual-channel elastic buffer inserted on any inter-router link (cw, ccw, sn or ns) of the mesh, so rows and columns can grow beyond 4 routers or be retimed without changing router RTL. Holds up to DEPTH packets per virtual channel (even/odd), uses the mesh send/ready handshake, and runs its own polarity so that writes and reads never touch the same VC FIFO in one cycle. It is the link primitive for the next-generation, width/size-parametrised mesh row and column generators.

## Interface
- PACKET_WIDTH, 64: packet width in bits.
- DEPTH, 2: entries per VC FIFO; power of two, ≥2.
- VC_BIT, 63: index of the packet bit selecting the VC (0 even, 1 odd).
- OCC_W, $clog2(DEPTH+1): occupancy counter width (localparam).

- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low.
- polarity_out  out  1  current polarity; 0 even, 1 odd.
- si  in  1  upstream send.
- ri  out  1  upstream ready: room in the VC matching the current polarity.
- di  in  PACKET_WIDTH  upstream data.
- so  out  1  downstream send.
- ro  in  1  downstream ready.
- do  out  PACKET_WIDTH  downstream data.
- occ_even  out  OCC_W  entries held in the even VC.
- occ_odd  out  OCC_W  entries held in the odd VC.
- err_vc  out  1  sticky flag: a packet was offered on the wrong VC for the current polarity.

## Operation
- Polarity register resets to 0 and toggles every cycle. p denotes the current value.
- Write side, in a cycle with polarity p:
  - ri = (occ of VC p) < DEPTH.
  - The block accepts a packet when si && ri && di[VC_BIT]==p. The packet goes to the tail of VC p.
  - If si && di[VC_BIT]!=p, the packet is dropped and err_vc sets. err_vc holds until reset.
  - If si is high while ri is low, the packet is not accepted. There is no error, and the upstream must hold si/di.
- Read side, in a cycle with polarity p:
  - Only VC !p drains.
  - so = ro && (occ of VC !p) > 0.
  - do = head of VC !p when so=1, otherwise 0.
  - When so=1 the head is popped at the clock edge.
- Writes always target VC p and reads always target VC !p, so one FIFO never sees a simultaneous push and pop.
- Each FIFO has separate read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH. The occupancy counter increments on push and decrements on pop, in the range 0..DEPTH.
- Full (occ==DEPTH): ri=0 in that VC's write phase. Stored data is not overwritten.
- Empty (occ==0): so=0 in that VC's read phase, whatever ro is.
- Packet contents pass through unmodified, VC bit included. Order is FIFO within each VC. There is no ordering guarantee between VCs.

## Timing
- Reset (reset=0, asynchronous), all outputs forced immediately:
  - polarity_out=0, occ_even=0, occ_odd=0, err_vc=0, so=0, do=0.
  - ri=1, since the even VC is empty.
- Reset asserted mid-operation flushes both FIFOs. In-flight packets are lost. No partial state survives.
- Deassertion is synchronised by the integrating top. The first rising edge after deassertion is an even cycle.
- ri, so and do are combinational from registered state, polarity and ro. There is no combinational path from si or di to any output.
- Latency: a packet accepted in an even cycle t is visible on do from cycle t+1, the next odd cycle, if ro=1. So minimum latency is 1 cycle. A packet not drained at t+1 next becomes eligible at t+3, t+5, and so on.
- Throughput: 1 packet per cycle aggregate; each VC gets 1 write slot and 1 read slot every 2 cycles.
- occ_* updates at the clock edge after a push or pop.

## Test plan
- Reset then idle: release reset, hold si=0 and ro=1 for 10 cycles -> polarity_out alternates 0,1,0,…; so=0; occ_even=occ_odd=0; ri=1 every cycle.
- Single packet: in an even cycle drive si=1, di=64'h0000_0000_0000_00A5 (bit63=0), ro=1 -> next cycle so=1 and do=64'h…A5; after that edge occ_even=0.
- Fill and backpressure, DEPTH=2: ro=0, send 3 even packets 0x1, 0x2, 0x3 on consecutive even cycles -> 0x1 and 0x2 accepted; ri=0 in the third even cycle with occ_even=2, and the upstream holds 0x3. Then ro=1 -> do=0x1 then 0x2 on successive odd cycles, after which 0x3 is accepted.
- Wrong VC: in an odd cycle send di with bit63=0 (value 0x7) -> packet dropped, occ_odd and occ_even unchanged, err_vc=1 and stays 1 until reset.
- Concurrent traffic: send even packet 0x10 at t (even) and odd packet 0x8000_0000_0000_0020 at t+1 with ro=1 throughout -> do=0x10 at t+1 and do=0x8000…0020 at t+2; no packet lost; both occ counters return to 0.
- Reset mid-operation: with occ_even=2 and occ_odd=1, pulse reset low for half a cycle -> all outputs go to their reset values immediately; after release, so stays 0 until new packets arrive.
